rx_baud_sched: RTL

//  Run-time baud selector and bit-timing scheduler for the UART receive path.

---
 rtl/rx_baud_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rx_baud_sched.sv
// Run-time baud selector and bit-timing scheduler for the UART receive path.
// Picks one RX_div oversample clock, emits os_tick/bit_strobe, and switches rate only when idle.
module rx_baud_sched #(
  parameter logic [1:0]  DEFAULT_SEL = 2'd3,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PH_W        = 4,
  parameter int unsigned SW_TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       T1200,
  input  logic       T2400,
  input  logic       T4800,
  input  logic       T9600,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_sel,
  output logic       cfg_ready,
  output logic       cfg_done,
  output logic       cfg_err,
  input  logic       rx_start,
  input  logic       rx_busy,
  output logic [1:0] cur_sel,
  output logic       os_tick,
  output logic       bit_strobe
);

  localparam int unsigned TMO_W = $clog2(SW_TIMEOUT + 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SW_TIMEOUT - 1);

  logic [3:0]       t_in, t_q, rise;
  logic             sel_rise, tick;
  logic [1:0]       state_q, state_d;
  logic [1:0]       cur_sel_q, cur_sel_d;
  logic [1:0]       nxt_sel_q, nxt_sel_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_strobe_q, bit_strobe_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_done_q, cfg_done_d;
  logic             cfg_err_q, cfg_err_d;

  assign t_in     = {T9600, T4800, T2400, T1200};
  assign rise     = t_in & ~t_q;
  assign sel_rise = rise[cur_sel_q];

  // Next-state, phase and output decode
  always_comb begin
    state_d      = state_q;
    cur_sel_d    = cur_sel_q;
    nxt_sel_d    = nxt_sel_q;
    phase_d      = phase_q;
    tmo_d        = tmo_q;
    tick         = 1'b0;
    cfg_done_d   = 1'b0;
    cfg_err_d    = 1'b0;

    case (state_q)
      ST_RUN: begin
        tick = sel_rise;
        if (cfg_valid && cfg_ready_q) begin
          if (cfg_sel == cur_sel_q) begin
            cfg_done_d = 1'b1;
          end else begin
            nxt_sel_d = cfg_sel;
            state_d   = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        tick = sel_rise;
        if (!rx_busy) begin
          cur_sel_d = nxt_sel_q;
          tmo_d     = '0;
          state_d   = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        // The alignment edge re-phases the counter but is not itself a tick
        if (sel_rise) begin
          phase_d    = '0;
          state_d    = ST_RUN;
          cfg_done_d = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d    = ST_RUN;
          cfg_done_d = 1'b1;
          cfg_err_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (rx_start) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end

    os_tick_d    = tick;
    bit_strobe_d = tick & rx_busy & ~rx_start & (phase_q == PH_MID);
    cfg_ready_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q          <= '0;
      state_q      <= ST_RUN;
      cur_sel_q    <= DEFAULT_SEL;
      nxt_sel_q    <= DEFAULT_SEL;
      phase_q      <= '0;
      tmo_q        <= '0;
      os_tick_q    <= 1'b0;
      bit_strobe_q <= 1'b0;
      cfg_ready_q  <= 1'b1;
      cfg_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      t_q          <= t_in;
      state_q      <= state_d;
      cur_sel_q    <= cur_sel_d;
      nxt_sel_q    <= nxt_sel_d;
      phase_q      <= phase_d;
      tmo_q        <= tmo_d;
      os_tick_q    <= os_tick_d;
      bit_strobe_q <= bit_strobe_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_done_q   <= cfg_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign cfg_done   = cfg_done_q;
  assign cfg_err    = cfg_err_q;
  assign cur_sel    = cur_sel_q;
  assign os_tick    = os_tick_q;
  assign bit_strobe = bit_strobe_q;

endmodule
